// File: rtl/tc_status_pkg.sv
// Shared types and ASCII constants for the testcase status reporter.
// Optional watchdog is enabled by defining TC_REPORT_TIMEOUT_EN.
package tc_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PFX_PASS = 2'd0,
    PFX_FAIL = 2'd1,
    PFX_TOUT = 2'd2
  } pfx_t;

  localparam int PFX_LEN = 5;

  localparam logic [39:0] ASC_PASS = "PASS ";
  localparam logic [39:0] ASC_FAIL = "FAIL ";
  localparam logic [39:0] ASC_TOUT = "TOUT ";

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/tc_msg_serializer.sv
// Walks the verdict line one byte at a time onto a valid/ready stream.
// Line fields come from registers held stable by the parent during REPORT.
module tc_msg_serializer
  import tc_status_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  pfx_t             pfx,
  input  logic [ID_W-1:0]  id,
  input  logic [ERR_W-1:0] err,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             done
);

  localparam int ID_N   = ID_W / 4;
  localparam int ERR_N  = ERR_W / 4;
  localparam int ID_POS = PFX_LEN;
  localparam int SP_POS = ID_POS + ID_N;
  localparam int ER_POS = SP_POS + 1;
  localparam int LF_POS = ER_POS + ERR_N;
  localparam int IW     = $clog2(LF_POS + 1);

  localparam logic [IW-1:0] LAST = IW'(LF_POS);

  logic [IW-1:0] idx;
  logic [39:0]   pfx_str;
  logic [7:0]    byte_c;
  int            pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      idx     <= '0;
    end else if (start) begin
      m_valid <= 1'b1;
      idx     <= '0;
    end else if (m_valid && m_ready) begin
      if (idx == LAST) begin
        m_valid <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_comb begin
    pfx_str = ASC_FAIL;
    unique case (pfx)
      PFX_PASS: pfx_str = ASC_PASS;
      PFX_FAIL: pfx_str = ASC_FAIL;
      PFX_TOUT: pfx_str = ASC_TOUT;
      default:  pfx_str = ASC_FAIL;
    endcase
  end

  // Hex fields are emitted MSB nibble first.
  always_comb begin
    pos    = int'(idx);
    byte_c = ASC_LF;
    if (pos < ID_POS) begin
      byte_c = pfx_str[(PFX_LEN-1-pos)*8 +: 8];
    end else if (pos < SP_POS) begin
      byte_c = nibble_to_ascii(id[(SP_POS-1-pos)*4 +: 4]);
    end else if (pos == SP_POS) begin
      byte_c = ASC_SPACE;
    end else if (pos < LF_POS) begin
      byte_c = nibble_to_ascii(err[(LF_POS-1-pos)*4 +: 4]);
    end
  end

  assign m_data = m_valid ? byte_c : 8'h00;
  assign done   = m_valid && m_ready && (idx == LAST);

endmodule

// File: rtl/tc_status_reporter.sv
// Collects per-testcase check results and emits one ASCII verdict line.
// Define TC_REPORT_TIMEOUT_EN to add the RUNNING-state watchdog.
module tc_status_reporter
  import tc_status_pkg::*;
#(
  parameter int GC_ID_WIDTH       = 8,
  parameter int GC_ERR_WIDTH      = 16,
  parameter int GC_TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tc_start,
  input  logic [GC_ID_WIDTH-1:0]  tc_id,
  input  logic                    tc_end,
  input  logic                    chk_valid,
  input  logic                    chk_pass,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic [GC_ERR_WIDTH-1:0] err_count,
  output logic                    protocol_err
);

  localparam logic [GC_ERR_WIDTH-1:0] ERR_MAX = '1;

  if ((GC_ID_WIDTH % 4) != 0 || GC_ID_WIDTH < 4 || GC_ID_WIDTH > 32)
    $error("GC_ID_WIDTH must be a multiple of 4 in 4..32");
  if ((GC_ERR_WIDTH % 4) != 0 || GC_ERR_WIDTH < 4 || GC_ERR_WIDTH > 32)
    $error("GC_ERR_WIDTH must be a multiple of 4 in 4..32");
  if (GC_TIMEOUT_CYCLES < 1)
    $error("GC_TIMEOUT_CYCLES must be positive");

  state_t state;
  state_t state_nx;

  logic [GC_ID_WIDTH-1:0]  id_q;
  logic [GC_ERR_WIDTH-1:0] err_q;
  logic                    tout_q;
  logic                    tout_hit;
  logic                    ser_start;
  logic                    ser_done;
  logic                    err_inc;
  logic                    proto_viol;
  pfx_t                    pfx;

`ifdef TC_REPORT_TIMEOUT_EN
  localparam int TW = $clog2(GC_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(GC_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst || state != ST_RUNNING) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // A real tc_end in the limit cycle takes precedence over the watchdog.
  assign tout_hit = (state == ST_RUNNING) && !tc_end && (tcnt == T_LAST);
`else
  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (tc_start) state_nx = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (tc_end || tout_hit) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        if (ser_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  assign ser_start = (state == ST_RUNNING) && (tc_end || tout_hit);

  assign err_inc = (state == ST_RUNNING) && chk_valid &&
                   !chk_pass && (err_q != ERR_MAX);

  assign proto_viol = (tc_start && state != ST_IDLE) ||
                      (tc_end && state != ST_RUNNING);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q         <= '0;
      err_q        <= '0;
      tout_q       <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && tc_start) begin
        id_q   <= tc_id;
        err_q  <= '0;
        tout_q <= 1'b0;
      end
      if (err_inc) begin
        err_q <= err_q + GC_ERR_WIDTH'(1);
      end
      if (ser_start) begin
        tout_q <= tout_hit;
      end
      if (proto_viol) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Verdict uses the registered count, which already includes the tc_end cycle.
  always_comb begin
    pfx = PFX_FAIL;
    unique case (1'b1)
      tout_q:       pfx = PFX_TOUT;
      err_q == '0:  pfx = PFX_PASS;
      default:      pfx = PFX_FAIL;
    endcase
  end

  assign err_count = err_q;

  tc_msg_serializer #(
    .ID_W  (GC_ID_WIDTH),
    .ERR_W (GC_ERR_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (ser_start),
    .pfx     (pfx),
    .id      (id_q),
    .err     (err_q),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_tc_status_reporter.sv
// Directed bench for tc_status_reporter: vector table plus corner sequences.
// Runs a 16-bit and a 4-bit error-width instance on shared stimulus.
module tb_tc_status_reporter;

`ifdef TC_REPORT_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1000000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tc_start;
  logic        tc_end;
  logic        chk_valid;
  logic        chk_pass;
  logic        m_ready;
  logic [7:0]  tc_id;

  logic [7:0]  m_data;
  logic        m_valid;
  logic        busy;
  logic [15:0] err_count;
  logic        perr;

  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_busy;
  logic [3:0]  s_err;
  logic        s_perr;

  always #5 clk = ~clk;

  tc_status_reporter #(
    .GC_ID_WIDTH       (8),
    .GC_ERR_WIDTH      (16),
    .GC_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tc_start     (tc_start),
    .tc_id        (tc_id),
    .tc_end       (tc_end),
    .chk_valid    (chk_valid),
    .chk_pass     (chk_pass),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .err_count    (err_count),
    .protocol_err (perr)
  );

  tc_status_reporter #(
    .GC_ID_WIDTH       (8),
    .GC_ERR_WIDTH      (4),
    .GC_TIMEOUT_CYCLES (TO)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .tc_start     (tc_start),
    .tc_id        (tc_id),
    .tc_end       (tc_end),
    .chk_valid    (chk_valid),
    .chk_pass     (chk_pass),
    .m_data       (s_data),
    .m_valid      (s_valid),
    .m_ready      (m_ready),
    .busy         (s_busy),
    .err_count    (s_err),
    .protocol_err (s_perr)
  );

  typedef struct {
    logic [7:0]  id;
    int          n_chk;
    int          n_fail;
    bit          end_chk;
    bit          bp;
    logic [15:0] exp_err;
    string       exp;
  } vec_t;

  vec_t  vecs[6];
  int    n_asrt = 0;
  int    n_fail = 0;
  string got_m;
  string got_s;
  int    cyc_used;
  int    stab_err;

  function automatic vec_t mk(
    input logic [7:0] id, input int nc, input int nf,
    input bit ec, input bit bp, input logic [15:0] ee,
    input string ex
  );
    vec_t v;
    v.id = id; v.n_chk = nc; v.n_fail = nf;
    v.end_chk = ec; v.bp = bp; v.exp_err = ee; v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act,
                       input string exp);
    n_asrt++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tc_start = 1'b0; tc_end = 1'b0;
    chk_valid = 1'b0; chk_pass = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drains the main line; records bytes from both instances.
  task automatic collect(input bit bp);
    logic [7:0] hold;
    bit         stalled;
    bit         done_m;
    int         cyc;
    got_m = ""; got_s = "";
    hold = 8'h00; stalled = 0; done_m = 0;
    stab_err = 0; cyc = 0;
    while (!done_m && cyc < 100) begin
      if (stalled && (!m_valid || m_data !== hold)) stab_err++;
      m_ready = bp ? ((cyc % 2) == 1) : 1'b1;
      stalled = 0;
      if (s_valid && m_ready) got_s = {got_s, $sformatf("%c", s_data)};
      if (m_valid && m_ready) begin
        got_m = {got_m, $sformatf("%c", m_data)};
        if (m_data == 8'h0A) done_m = 1;
      end else if (m_valid) begin
        stalled = 1;
        hold = m_data;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b1;
    cyc_used = cyc;
    if (!done_m) chk("collect_budget", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    tc_id = v.id; tc_start = 1'b1;
    @(negedge clk);
    tc_start = 1'b0;
    for (int k = 0; k < v.n_chk; k++) begin
      chk_valid = 1'b1;
      chk_pass  = (k < v.n_chk - v.n_fail);
      tc_end    = v.end_chk && (k == v.n_chk - 1);
      @(negedge clk);
    end
    chk_valid = 1'b0; chk_pass = 1'b0;
    if (!(v.end_chk && v.n_chk > 0)) begin
      tc_end = 1'b1;
      @(negedge clk);
    end
    tc_end = 1'b0;
    chk({tag, "_latency"}, m_valid, 1);
    chk({tag, "_busy"}, busy, 1);
    collect(v.bp);
    chk_s({tag, "_line"}, got_m, v.exp);
    if (v.bp) chk({tag, "_stable"}, stab_err, 0);
    else chk({tag, "_contig"}, cyc_used, v.exp.len());
    chk({tag, "_err"}, err_count, v.exp_err);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_valid_fall"}, m_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tc_id = 8'h00;
    rst = 1'b1; tc_start = 1'b0; tc_end = 1'b0;
    chk_valid = 1'b0; chk_pass = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    chk("rst_perr", perr, 0);

    vecs[0] = mk(8'h03, 5, 0, 0, 0, 16'h0000, "PASS 03 0000\n");
    vecs[1] = mk(8'hA7, 6, 3, 1, 0, 16'h0003, "FAIL A7 0003\n");
    vecs[2] = mk(8'h03, 5, 0, 0, 1, 16'h0000, "PASS 03 0000\n");
    vecs[3] = mk(8'h5C, 20, 18, 0, 1, 16'h0012, "FAIL 5C 0012\n");
    vecs[4] = mk(8'hFF, 0, 0, 0, 0, 16'h0000, "PASS FF 0000\n");
    vecs[5] = mk(8'h0B, 11, 11, 1, 1, 16'h000B, "FAIL 0B 000B\n");

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    chk("vec_perr_clean", perr, 0);

    // Saturation on the 4-bit counter instance.
    run_vec(mk(8'h03, 20, 20, 0, 0, 16'h0014, "FAIL 03 0014\n"), "sat_main");
    chk_s("sat_line", got_s, "FAIL 03 F\n");
    chk("sat_err", s_err, 4'hF);

    // End in IDLE, then double start: first ID kept.
    do_reset();
    tc_end = 1'b1;
    @(negedge clk);
    tc_end = 1'b0;
    chk("proto_end_idle", perr, 1);
    chk("proto_end_idle_busy", busy, 0);
    tc_id = 8'h21; tc_start = 1'b1;
    @(negedge clk);
    tc_id = 8'h99;
    @(negedge clk);
    tc_start = 1'b0; tc_end = 1'b1;
    @(negedge clk);
    tc_end = 1'b0;
    chk("proto_latency", m_valid, 1);
    collect(0);
    chk_s("proto_line", got_m, "PASS 21 0000\n");
    chk("proto_sticky", perr, 1);

    // Start and end together in IDLE: start wins.
    do_reset();
    chk("both_perr_cleared", perr, 0);
    tc_id = 8'h44; tc_start = 1'b1; tc_end = 1'b1;
    @(negedge clk);
    tc_start = 1'b0; tc_end = 1'b0;
    chk("both_perr", perr, 1);
    chk("both_busy", busy, 1);
    tc_end = 1'b1;
    @(negedge clk);
    tc_end = 1'b0;
    collect(0);
    chk_s("both_line", got_m, "PASS 44 0000\n");

    // Reset after four bytes of a report.
    do_reset();
    tc_id = 8'h55; tc_start = 1'b1;
    @(negedge clk);
    tc_start = 1'b0; chk_valid = 1'b1; chk_pass = 1'b0;
    repeat (2) @(negedge clk);
    chk_valid = 1'b0; tc_end = 1'b1;
    @(negedge clk);
    tc_end = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_err", err_count, 2);
    chk("mid_valid", m_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_count, 0);
    @(negedge clk);
    chk("mid_idle_valid", m_valid, 0);
    run_vec(vecs[1], "after_rst");

`ifdef TC_REPORT_TIMEOUT_EN
    do_reset();
    tc_id = 8'h03; tc_start = 1'b1;
    @(negedge clk);
    tc_start = 1'b0;
    repeat (49) @(negedge clk);
    chk("tout_c50_valid", m_valid, 0);
    @(negedge clk);
    chk("tout_c51_valid", m_valid, 1);
    m_ready = 1'b0; tc_end = 1'b1;
    @(negedge clk);
    tc_end = 1'b0; m_ready = 1'b1;
    chk("tout_end_perr", perr, 1);
    collect(0);
    chk_s("tout_line", got_m, "TOUT 03 0000\n");
    chk("tout_busy_fall", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
